// File: rtl/dcache_tagarray_mp_if.sv
// dcache_tagarray_mp_if
//   Bundle of every signal between the dcache pipes and the tag array.
//   master: load/store pipes + refill path (drive requests, see results)
//   slave : the tag array itself
//
// Request semantics (no backpressure):
//   There is no ready. A read on port p is taken at a rising edge when
//   rd_en[p] is high and init_busy is low. rd_valid[p] pulses one cycle
//   later with rd_data[p]. A write is taken on the same condition
//   (wr_en high, init_busy low). Requests made while init_busy is high
//   are dropped, not held. The requester must retry them.
//
// Signals:
//   flush_req  pulse, starts a clear sweep when the array is idle
//   init_busy  high while the clear sweep runs
//   state_dbg  raw FSM state (0 = INIT, 1 = IDLE), for checkers
//   rd_en/rd_way/rd_idx  per-port read request, packed by port
//   rd_data/rd_valid     per-port registered read result
//   wr_en/wr_way/wr_idx/wr_data  single write port, wr_way multi-hot
interface dcache_tagarray_mp_if #(
  parameter int DATA_WIDTH = 44,
  parameter int ADDR_WIDTH = 6,
  parameter int WAY_NUM    = 4,
  parameter int RD_PORTS   = 3
);
  logic                           flush_req;
  logic                           init_busy;
  logic                           state_dbg;
  logic [RD_PORTS-1:0]            rd_en;
  logic [RD_PORTS*WAY_NUM-1:0]    rd_way;
  logic [RD_PORTS*ADDR_WIDTH-1:0] rd_idx;
  logic [RD_PORTS*DATA_WIDTH-1:0] rd_data;
  logic [RD_PORTS-1:0]            rd_valid;
  logic                           wr_en;
  logic [WAY_NUM-1:0]             wr_way;
  logic [ADDR_WIDTH-1:0]          wr_idx;
  logic [DATA_WIDTH-1:0]          wr_data;

  modport master (
    output flush_req, rd_en, rd_way, rd_idx, wr_en, wr_way, wr_idx, wr_data,
    input  init_busy, state_dbg, rd_data, rd_valid
  );

  modport slave (
    input  flush_req, rd_en, rd_way, rd_idx, wr_en, wr_way, wr_idx, wr_data,
    output init_busy, state_dbg, rd_data, rd_valid
  );
endinterface

// File: rtl/dcache_tagarray_mp.sv
// dcache_tagarray_mp
//   Multi-port dcache tag array. It has 2^ADDR_WIDTH sets x WAY_NUM ways
//   of DATA_WIDTH-bit entries, one write port and RD_PORTS registered read
//   ports. All storage is flops. A hardware sweep zeroes one set per cycle
//   after reset and after a flush_req pulse. While the sweep runs,
//   init_busy is high and every request is dropped.
//
// Ports:
//   clock  sole clock, rising edge
//   reset  asynchronous, active high; restarts the sweep from set 0
//   bus    dcache_tagarray_mp_if.slave (requests, results, init_busy)
//
// Optional feature macro: DCACHE_TAG_BYPASS_EN
//   defined     -> write-first. A read that collides with a same-cycle
//                  write sees wr_data on the written ways.
//   not defined -> read-first. A colliding read sees the pre-write contents.
module dcache_tagarray_mp #(
  parameter int DATA_WIDTH = 44,
  parameter int ADDR_WIDTH = 6,
  parameter int WAY_NUM    = 4,
  parameter int RD_PORTS   = 3
) (
  input logic                  clock,
  input logic                  reset,
  dcache_tagarray_mp_if.slave  bus
);

  localparam int SETS = 1 << ADDR_WIDTH;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    idle;

  logic [DATA_WIDTH-1:0]          mem [SETS][WAY_NUM];
  logic [DATA_WIDTH-1:0]          rd_next [RD_PORTS];
  logic [RD_PORTS*DATA_WIDTH-1:0] rd_data_q;
  logic [RD_PORTS-1:0]            rd_valid_q;

  assign idle = (state_q == ST_IDLE);

  // Next-state logic. The sweep counter wraps to 0 on the last set, so it
  // already reads 0 when IDLE is entered.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == ADDR_WIDTH'(SETS - 1)) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (bus.flush_req) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Storage has no reset. The sweep defines the contents before the first
  // accepted request. A write at the flush edge lands in storage, but the
  // following sweep clears it again.
  always_ff @(posedge clock) begin
    if (!idle) begin
      for (int w = 0; w < WAY_NUM; w++) begin
        mem[cnt_q][w] <= '0;
      end
    end else if (bus.wr_en) begin
      for (int w = 0; w < WAY_NUM; w++) begin
        if (bus.wr_way[w]) begin
          mem[bus.wr_idx][w] <= bus.wr_data;
        end
      end
    end
  end

  // Per-port read mux: OR of every selected way, so zero ways give 0 and
  // multi-hot gives the OR of the selected ways.
  always_comb begin
    logic [DATA_WIDTH-1:0] entry;
    logic [ADDR_WIDTH-1:0] idx;
    entry = '0;
    idx   = '0;
    for (int p = 0; p < RD_PORTS; p++) begin
      rd_next[p] = '0;
      idx        = bus.rd_idx[p*ADDR_WIDTH +: ADDR_WIDTH];
      for (int w = 0; w < WAY_NUM; w++) begin
        entry = mem[idx][w];
`ifdef DCACHE_TAG_BYPASS_EN
        if (bus.wr_en && (bus.wr_idx == idx) && bus.wr_way[w]) begin
          entry = bus.wr_data;
        end
`endif
        if (bus.rd_way[p*WAY_NUM + w]) begin
          rd_next[p] = rd_next[p] | entry;
        end
      end
    end
  end

  // Registered read outputs. Data holds whenever no read is accepted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_data_q  <= '0;
      rd_valid_q <= '0;
    end else begin
      for (int p = 0; p < RD_PORTS; p++) begin
        rd_valid_q[p] <= idle && bus.rd_en[p];
        if (idle && bus.rd_en[p]) begin
          rd_data_q[p*DATA_WIDTH +: DATA_WIDTH] <= rd_next[p];
        end
      end
    end
  end

  assign bus.rd_data   = rd_data_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.init_busy = !idle;
  assign bus.state_dbg = state_q;

endmodule
